// File: rtl/cell_part_arbiter.sv
// Round-robin, burst-limited arbiter that merges the save_cells partition drains into one
// readout stream, plus a frame sequencer counting flag_buff_valid rising edges.
// Define CELL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no rr pointer).
module cell_part_arbiter #(
  parameter int N_REQ           = 3,
  parameter int DATA_W          = 48,
  parameter int MAX_BURST       = 16,
  parameter int PARTS_PER_FRAME = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flag_buff_valid,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  output logic [1:0]              m_src,
  output logic                    frame_tick,
  output logic                    busy,
  output logic [1:0]              dbg_state
);
  // Handshake: a beat transfers on any cycle where valid and ready are both high;
  // a requester holds its beat stable while valid is high and ready is low.

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARB = 2'd1, ST_XFER = 2'd2} state_t;

  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int PART_W = $clog2(PARTS_PER_FRAME + 1);

  state_t             r_state;
  logic [1:0]         r_sel;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [PART_W-1:0]  r_part_cnt;
  logic               r_flag_q;
  logic               r_frame_tick;

  logic [1:0] w_start;
  logic [1:0] w_hi;
  logic [1:0] w_lo;
  logic       w_hi_found;
  logic       w_lo_found;
  logic       w_cap;
  logic       w_accept;
  logic       w_edge;

`ifdef CELL_ARB_FIXED_PRIO_EN
  assign w_start = 2'd0;
`else
  logic [1:0] r_rr_ptr;
  assign w_start = r_rr_ptr;
`endif

  // Lowest valid index at/above the start point wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = 2'd0;
    w_lo       = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo       = 2'(i);
        if (2'(i) >= w_start) begin
          w_hi_found = 1'b1;
          w_hi       = 2'(i);
        end
      end
    end
  end

  assign w_cap = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    m_src     = 2'd0;
    req_ready = '0;
    if (r_state == ST_XFER) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (r_sel == 2'(i)) begin
          m_valid      = req_valid[i];
          m_data       = req_data[i*DATA_W +: DATA_W];
          m_last       = req_last[i];
          req_ready[i] = m_ready;
        end
      end
      m_last = m_last | w_cap;
      m_src  = r_sel;
    end
  end

  assign w_accept = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= 2'd0;
      r_beat_cnt <= '0;
`ifndef CELL_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (|req_valid) r_state <= ST_ARB;
        ST_ARB: begin
          // Requests withdrawn before the grant is latched fall back to IDLE.
          if (w_lo_found) begin
            r_sel   <= w_hi_found ? w_hi : w_lo;
            r_state <= ST_XFER;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            if (m_last) begin
              r_state    <= ST_IDLE;
              r_beat_cnt <= '0;
`ifndef CELL_ARB_FIXED_PRIO_EN
              r_rr_ptr   <= (r_sel == 2'(N_REQ - 1)) ? 2'd0 : r_sel + 2'd1;
`endif
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // flag_q resets high so a level already asserted at reset release is not counted.
  assign w_edge = flag_buff_valid & ~r_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_q     <= 1'b1;
      r_part_cnt   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_flag_q     <= flag_buff_valid;
      r_frame_tick <= w_edge && (r_part_cnt == PART_W'(PARTS_PER_FRAME - 1));
      if (w_edge) begin
        if (r_part_cnt == PART_W'(PARTS_PER_FRAME - 1)) r_part_cnt <= '0;
        else r_part_cnt <= r_part_cnt + 1'b1;
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cell_part_arbiter.sv
// Bench for cell_part_arbiter: random requester drains checked each cycle against a
// grant-level reference model, plus directed latency, fairness, burst-cap, backpressure and frame cases.
module tb_cell_part_arbiter;
  localparam int N_REQ = 3, DATA_W = 48, MAX_BURST = 16, PPF = 6;

  logic clk = 1'b0;
  logic rst, flag_buff_valid, m_ready, m_valid, m_last, frame_tick, busy;
  logic [N_REQ-1:0] req_valid, req_last, req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0] m_data;
  logic [1:0] m_src, dbg_state;

  always #5 clk = ~clk;

  cell_part_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .PARTS_PER_FRAME(PPF)) dut (
    .clk(clk), .rst(rst), .flag_buff_valid(flag_buff_valid),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_src(m_src),
    .frame_tick(frame_tick), .busy(busy), .dbg_state(dbg_state)
  );

  int vectors = 0, miscompares = 0;
  logic [DATA_W-1:0] exp_q[$];

  // requester engine
  int rem[N_REQ];
  bit nolast[N_REQ];
  logic [15:0] seq_gen[N_REQ], exp_seq[N_REQ];
  logic [DATA_W-1:0] rq_data[N_REQ];
  int refill_pct, refill_min, refill_max, gap_pct, ready_mode;
  bit q_en;
  int q_src;

  // reference model state: mode 0 idle, 1 arbitrating, 2 transferring
  int md_mode, md_sel, md_cnt, md_ptr, md_part;
  bit md_flag_q, md_tick, md_known;

  // output snapshot taken at the falling edge
  logic snap_mv, snap_ml, snap_busy, snap_tick, snap_mready, snap_acc;
  logic [1:0] snap_src, snap_state;
  logic [N_REQ-1:0] snap_rr, snap_acc_v;
  logic [DATA_W-1:0] snap_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = rq_data[i];
      req_last[i] = (rem[i] == 1) && !nolast[i];
    end
  endtask

  task automatic new_beat(input int i);
    rq_data[i] = {8'(i), seq_gen[i], 24'($urandom)};
    if (q_en && i == q_src) exp_q.push_back(rq_data[i]);
    seq_gen[i]++;
  endtask

  task automatic start_drain(input int i, input int n);
    rem[i] = n;
    new_beat(i);
    req_valid[i] = 1'b1;
    drive_reqs();
  endtask

  task automatic clear_engine();
    for (int i = 0; i < N_REQ; i++) begin
      rem[i] = 0;
      nolast[i] = 1'b0;
      exp_seq[i] = seq_gen[i];
    end
    req_valid = '0;
    refill_pct = 0;
    gap_pct = 0;
    drive_reqs();
  endtask

  task automatic engine_update();
    for (int i = 0; i < N_REQ; i++) begin
      if (snap_acc_v[i]) begin
        rem[i]--;
        if (rem[i] > 0) new_beat(i);
      end
      if (rem[i] == 0 && refill_pct > 0 && $urandom_range(0, 99) < refill_pct) begin
        rem[i] = $urandom_range(refill_min, refill_max);
        new_beat(i);
      end
      req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 99) >= gap_pct);
    end
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    drive_reqs();
  endtask

  task automatic model_step();
    bit edge_seen;
    int start;
    if (rst) begin
      md_known = 1'b1; md_mode = 0; md_sel = 0; md_cnt = 0; md_ptr = 0;
      md_part = 0; md_flag_q = 1'b1; md_tick = 1'b0;
    end else begin
      edge_seen = flag_buff_valid && !md_flag_q;
      md_tick = edge_seen && (md_part == PPF - 1);
      if (edge_seen) md_part = (md_part + 1) % PPF;
      md_flag_q = flag_buff_valid;
      if (md_mode == 0) begin
        if (req_valid != '0) md_mode = 1;
      end else if (md_mode == 1) begin
`ifdef CELL_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = md_ptr;
`endif
        md_mode = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
          if (req_valid[(start + k) % N_REQ]) begin
            md_sel = (start + k) % N_REQ;
            md_mode = 2;
          end
        end
      end else if (req_valid[md_sel] && m_ready) begin
        if (req_last[md_sel] || md_cnt == MAX_BURST - 1) begin
          md_mode = 0; md_cnt = 0; md_ptr = (md_sel + 1) % N_REQ;
        end else begin
          md_cnt++;
        end
      end
    end
  endtask

  task automatic check_model();
    bit xfer;
    logic e_mv, e_ml;
    logic [N_REQ-1:0] e_rr;
    logic [DATA_W-1:0] e_data;
    if (md_known) begin
      xfer = (md_mode == 2);
      e_mv = 1'b0; e_ml = 1'b0; e_rr = '0; e_data = '0;
      if (xfer) begin
        e_mv = req_valid[md_sel];
        e_ml = req_last[md_sel] || (md_cnt == MAX_BURST - 1);
        e_rr[md_sel] = m_ready;
        e_data = req_data[md_sel*DATA_W +: DATA_W];
      end
      chk("m_valid", snap_mv, e_mv);
      chk("m_last", snap_ml, e_ml);
      chk("m_data", snap_data, e_data);
      chk("m_src", snap_src, xfer ? md_sel : 0);
      chk("req_ready", snap_rr, e_rr);
      chk("busy", snap_busy, md_mode != 0);
      chk("state", snap_state, md_mode);
      chk("frame_tick", snap_tick, md_tick);
      if (snap_acc && snap_src < N_REQ) begin
        chk("beat_seq", snap_data[39:24], exp_seq[snap_src]);
        exp_seq[snap_src]++;
        if (q_en && snap_src == q_src) begin
          if (exp_q.size() == 0) chk("bp_extra_beat", 1, 0);
          else chk("bp_data", snap_data, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    snap_mv = m_valid; snap_ml = m_last; snap_busy = busy; snap_tick = frame_tick;
    snap_mready = m_ready; snap_src = m_src; snap_state = dbg_state; snap_rr = req_ready;
    snap_data = m_data; snap_acc = m_valid & m_ready; snap_acc_v = req_ready & req_valid;
    check_model();
    @(posedge clk);
    model_step();
    #1;
    engine_update();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_engine();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int lens[$];
    int tick_at[$];
    int beats, total, pulses, guard;
    rst = 1'b1; flag_buff_valid = 1'b1; m_ready = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    ready_mode = 0; refill_min = 1; refill_max = 1; q_en = 1'b0; q_src = 0; md_known = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      seq_gen[i] = '0; rq_data[i] = '0;
    end
    clear_engine();

    // reset held with random inputs: every output must be zero
    for (int c = 0; c < 4; c++) begin
      req_valid = 3'($urandom);
      req_last = 3'($urandom);
      m_ready = 1'($urandom);
      for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = {16'($urandom), $urandom};
      tick();
      if (c > 0) begin
        chk("rst_ctrl", {snap_mv, snap_ml, snap_rr, snap_busy, snap_tick, snap_src}, 0);
        chk("rst_data", snap_data, 0);
      end
    end
    rst = 1'b0;
    clear_engine();

    // single requester, 4 beats: first beat two cycles after the request
    tick();
    start_drain(0, 4);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_m_valid", snap_mv, (k >= 2 && k <= 5));
      chk("t2_m_last", snap_ml, (k == 5));
      chk("t2_busy", snap_busy, (k >= 1 && k <= 5));
      if (k >= 2 && k <= 5) chk("t2_m_src", snap_src, 0);
    end

    // all three requesting continuously with 2-beat drains
    do_reset();
    refill_pct = 100; refill_min = 2; refill_max = 2;
    start_drain(0, 2); start_drain(1, 2); start_drain(2, 2);
    guard = 0;
    while (grants.size() < 6 && guard < 200) begin
      tick();
      if (snap_acc && snap_ml) grants.push_back(int'(snap_src));
      guard++;
    end
    chk("t3_grant_count", grants.size(), 6);
    for (int g = 0; g < grants.size(); g++) begin
`ifdef CELL_ARB_FIXED_PRIO_EN
      chk("t3_grant", grants[g], 0);
`else
      chk("t3_grant", grants[g], g % 3);
`endif
    end

    // burst cap: 40 beats with no last marker -> 16, 16, then 8 pending
    do_reset();
    nolast[1] = 1'b1;
    start_drain(1, 40);
    beats = 0; total = 0; guard = 0;
    while (total < 40 && guard < 200) begin
      tick();
      if (snap_acc) begin
        beats++; total++;
        if (snap_ml) begin
          lens.push_back(beats);
          beats = 0;
        end
      end
      guard++;
    end
    chk("t4_total", total, 40);
    chk("t4_capped_grants", lens.size(), 2);
    for (int g = 0; g < lens.size(); g++) chk("t4_burst_len", lens[g], 16);
    chk("t4_tail_beats", beats, 8);

    // backpressure: m_ready toggles every cycle
    do_reset();
    q_en = 1'b1; q_src = 2; ready_mode = 1; m_ready = 1'b1;
    start_drain(2, 6);
    total = 0; guard = 0;
    while (total < 6 && guard < 100) begin
      tick();
      if (snap_mv) chk("t5_ready_mirror", snap_rr, {snap_mready, 2'b00});
      if (snap_acc) total++;
      guard++;
    end
    repeat (4) tick();
    chk("t5_beats", total, 6);
    chk("t5_queue_drained", exp_q.size(), 0);
    q_en = 1'b0; ready_mode = 0;

    // frames: flag high through reset release, then 13 pulses
    flag_buff_valid = 1'b1;
    do_reset();
    pulses = 0;
    for (int p = 1; p <= 13; p++) begin
      flag_buff_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        tick();
        if (snap_tick) tick_at.push_back(pulses);
      end
      flag_buff_valid = 1'b1;
      pulses = p;
      repeat ($urandom_range(1, 3)) begin
        tick();
        if (snap_tick) tick_at.push_back(pulses);
      end
    end
    repeat (3) begin
      tick();
      if (snap_tick) tick_at.push_back(pulses);
    end
    chk("t6_tick_count", tick_at.size(), 2);
    if (tick_at.size() >= 2) begin
      chk("t6_first_tick_pulse", tick_at[0], 6);
      chk("t6_second_tick_pulse", tick_at[1], 12);
    end

    // reset in the middle of a burst
    start_drain(0, 10);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    tick();
    chk("t6_rst_mid_ctrl", {snap_mv, snap_ml, snap_rr, snap_busy}, 0);
    chk("t6_rst_mid_data", snap_data, 0);
    rst = 1'b0;
    clear_engine();

    // random traffic with gaps, random backpressure, flag noise and occasional reset
    do_reset();
    refill_pct = 20; refill_min = 1; refill_max = 20; gap_pct = 15; ready_mode = 2;
    nolast[1] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) flag_buff_valid = ~flag_buff_valid;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
